// File: rtl/div_if.sv
// Request/response bundle between the execute stage and the multi-cycle divider.
interface div_if #(parameter int WIDTH = 32);
  logic             start;
  logic [5:0]       ALUControl;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] resultDiv;

  modport master (
    output start, ALUControl, operand1, operand2,
    input  busy, done, resultDiv
  );

  modport slave (
    input  start, ALUControl, operand1, operand2,
    output busy, done, resultDiv
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow are resolved at accept and skip the iteration phase.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic   clk,
  input  logic   rst_n,
  div_if.slave   bus
);

  localparam int CW = 6;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } stateType;

  stateType state, nextState;

  logic             validOp;
  logic             isSigned;
  logic             isRem;
  logic             divByZero;
  logic             overflow;
  logic             special;
  logic             accept;
  logic             busyInt;
  logic             doneInt;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;

  logic [WIDTH-1:0] dividendReg;
  logic [WIDTH-1:0] divisorReg;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quotReg;
  logic [CW-1:0]    count;
  logic             remSel;
  logic             quotNeg;
  logic             remNeg;
  logic [WIDTH-1:0] resultReg;

  logic [WIDTH+1:0] trial;
  logic             qBit;
  logic [WIDTH-1:0] nextRem;
  logic [WIDTH-1:0] nextQuot;
  logic [WIDTH-1:0] fixedResult;

  // The four RV32M divide codes share the prefix 0101; bit0 selects unsigned, bit1 remainder.
  assign validOp   = (bus.ALUControl[5:2] == 4'b0101);
  assign isSigned  = ~bus.ALUControl[0];
  assign isRem     = bus.ALUControl[1];
  assign divByZero = (bus.operand2 == '0);
  assign overflow  = isSigned && (bus.operand1 == MIN_NEG) && (bus.operand2 == '1);
  assign special   = divByZero || overflow;
  assign magA      = (isSigned && bus.operand1[WIDTH-1]) ? -bus.operand1 : bus.operand1;
  assign magB      = (isSigned && bus.operand2[WIDTH-1]) ? -bus.operand2 : bus.operand2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    busyInt   = 1'b0;
    doneInt   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && validOp) begin
          accept    = 1'b1;
          nextState = special ? DONE : CALC;
        end
      end
      CALC: begin
        busyInt = 1'b1;
        if (count == LAST_ITER) begin
          nextState = DONE;
        end
      end
      DONE: begin
        doneInt   = 1'b1;
        nextState = IDLE;
        if (bus.start && validOp) begin
          accept    = 1'b1;
          nextState = special ? DONE : CALC;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // The shifted partial remainder keeps its top bit, so unsigned divisors above 2^(WIDTH-1) still work.
  assign trial       = {1'b0, remReg, dividendReg[WIDTH-1]} - {2'b00, divisorReg};
  assign qBit        = ~trial[WIDTH+1];
  assign nextRem     = qBit ? trial[WIDTH-1:0] : {remReg[WIDTH-2:0], dividendReg[WIDTH-1]};
  assign nextQuot    = {quotReg[WIDTH-2:0], qBit};
  assign fixedResult = remSel ? (remNeg  ? -nextRem  : nextRem)
                              : (quotNeg ? -nextQuot : nextQuot);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividendReg <= '0;
      divisorReg  <= '0;
      remReg      <= '0;
      quotReg     <= '0;
      count       <= '0;
      remSel      <= 1'b0;
      quotNeg     <= 1'b0;
      remNeg      <= 1'b0;
      resultReg   <= '0;
    end else if (accept) begin
      dividendReg <= magA;
      divisorReg  <= magB;
      remReg      <= '0;
      quotReg     <= '0;
      count       <= '0;
      remSel      <= isRem;
      quotNeg     <= isSigned && (bus.operand1[WIDTH-1] ^ bus.operand2[WIDTH-1]);
      remNeg      <= isSigned && bus.operand1[WIDTH-1];
      if (divByZero) begin
        resultReg <= isRem ? bus.operand1 : '1;
      end else if (overflow) begin
        resultReg <= isRem ? '0 : MIN_NEG;
      end
    end else if (state == CALC) begin
      dividendReg <= {dividendReg[WIDTH-2:0], 1'b0};
      remReg      <= nextRem;
      quotReg     <= nextQuot;
      count       <= count + 1'b1;
      if (count == LAST_ITER) begin
        resultReg <= fixedResult;
      end
    end
  end

  assign bus.busy      = busyInt;
  assign bus.done      = doneInt;
  assign bus.resultDiv = resultReg;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle integer divide/remainder unit for the RV32M DIV, DIVU, REM and REMU instructions.
- Sits in the execute stage beside the combinational ALU and is fed the same ALUControl code and operands.
- The result is consumed by the execute result mux. The pipeline holds execute stalled while busy is high.
- Uses a radix-2 restoring algorithm: one quotient bit per cycle.

Parameters:
WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request pulse; sampled only in IDLE or DONE.
ALUControl  input  6  op select: 6'b010100 DIV, 6'b010101 DIVU, 6'b010110 REM, 6'b010111 REMU.
operand1  input  WIDTH  dividend.
operand2  input  WIDTH  divisor.
busy  output  1  high while an operation is in progress (state CALC).
done  output  1  one-cycle pulse; resultDiv valid in that cycle.
resultDiv  output  WIDTH  quotient or remainder, held until the next accepted start.

Behaviour:
Clock and reset:
- One clock domain (clk).
- rst_n is asynchronous and active-low.
- Reset (asserted): state=IDLE; busy=0, done=0, resultDiv=0; internal registers cleared.
- Reset mid-operation aborts the operation with no result produced.

States: IDLE, CALC, DONE.

Accepting a request:
- Request accepted when start=1 and ALUControl is one of the four codes and state is IDLE or DONE.
- On accept, latch: operands, signed flag (DIV/REM), remainder-select flag (REM/REMU), and sign of the result.
- Inputs may change freely after the accept edge.
- start with any other ALUControl code: ignored, stay/return IDLE, no done.
- start in CALC: ignored, no queueing.

Special cases (resolved at accept, skip CALC; next state DONE; done one cycle after accept):
- Divisor==0: quotient = all ones (-1); remainder = dividend.
- Signed overflow, dividend=0x80000000 and divisor=0xFFFFFFFF with DIV/REM: quotient = 0x80000000; remainder = 0.

Normal path:
- Signed ops take the two's-complement magnitude of each operand; unsigned ops use operands as-is.
- State CALC runs exactly WIDTH cycles with a 6-bit iteration counter, 0..WIDTH-1.
- Each cycle: partial remainder R = {R[WIDTH-2:0], dividend MSB}, shifted with the dividend.
  - If R >= divisor: R -= divisor and quotient bit = 1.
  - Else quotient bit = 0.
  - Subtraction is WIDTH+1 bits wide to catch the borrow.
- After the last iteration, go to DONE. Sign fix-up is applied when loading resultDiv:
  - Quotient is negated if the operand signs differ (signed ops only).
  - Remainder is negated if the dividend was negative (signed ops only).
  - The remainder sign always follows the dividend.

Timing:
- Accept at edge 0 → busy=1 during cycles 1..WIDTH → done=1 and resultDiv valid in cycle WIDTH+1 (cycle 33 for WIDTH=32).
- busy=0 in IDLE and DONE; busy is never high in the same cycle as done.
- DONE lasts one cycle; then IDLE, or CALC/DONE directly if a new start is accepted in DONE (back-to-back).
- resultDiv changes only when entering DONE.
- Counter and quotient registers wrap/clear on each accept; no stale bits carry between operations.

Test Plan:
- DIVU 100/7, start one cycle: busy high 32 cycles; done pulse in cycle 33 after accept; resultDiv=14. Same with REMU → 2.
- DIV -7/2 → -3 (0xFFFFFFFD); REM -7/2 → -1; DIV 7/-2 → -3; REM 7/-2 → 1.
- Divide by zero: DIVU 0x1234/0 → 0xFFFFFFFF with done one cycle after accept; REM 0x1234/0 → 0x1234.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0; both complete in one cycle.
- Handshake:
  - start reasserted in CALC is ignored, and operands changed mid-CALC do not alter the result.
  - start with ALUControl=6'b000010 gives no busy and no done.
  - Back-to-back start in the DONE cycle accepted; second result correct.
- rst_n pulsed low at cycle 10 of CALC: busy/done/resultDiv go 0 immediately, no done follows, and a new DIVU 9/3 afterwards returns 3.
